timer_dev: RTL and testbench

Memory-mapped countdown timer that answers the CPU's data-memory store/load port. It decodes word address, write strobe, byte-enable and write data, and returns read data combinationally, like the data memory. A small state machine loads, decrements and reloads a 32-bit counter and raises a maskable interrupt line on expiry. It sits beside the data memory on the core's data bus; the top level selects it by address range.

---
 rtl/timer_dev.sv | 124 ++++++++++++
 tb/tb_timer_dev.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer on the data-memory bus: CTRL/PRESET/COUNT registers,
// a load/count/expire FSM and a maskable, registered interrupt line.
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;       // {IM, MODE[1:0], EN}
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        if_q, if_d;
    logic        irq_q, irq_d;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        ctrl_en_written;

    assign wr_ctrl         = we && (addr == ADDR_CTRL);
    assign wr_preset       = we && (addr == ADDR_PRESET);
    assign ctrl_en_written = wr_ctrl && be[0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        if_d     = if_q;
        irq_d    = if_q & ctrl_q[3];

        if (ctrl_en_written) begin
            ctrl_d = wdata[3:0];
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_preset && be[i]) begin
                preset_d[8*i +: 8] = wdata[8*i +: 8];
            end
        end

        // The FSM always decides from the registered CTRL, even when CTRL is being written.
        case (state_q)
            IDLE: begin
                if (ctrl_q[0]) state_d = LOAD;
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    state_d = INT;
                end
            end
            INT: begin
                if (ctrl_q[2:1] == 2'b01) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                    if (!ctrl_en_written) ctrl_d[0] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Set on INT entry overrides a same-edge clear from a register write.
        if (wr_ctrl || wr_preset) if_d = 1'b0;
        if (state_d == INT && state_q != INT) if_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            if_q     <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            if_q     <= if_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = {28'd0, ctrl_q};
            ADDR_PRESET: rdata = preset_q;
            ADDR_COUNT:  rdata = count_q;
            default:     rdata = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: a cycle-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_tests;
    int n_fail;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: timer phases and the register file, advanced once per rising edge.
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    logic [3:0]  m_ctrl   = '0;
    logic [31:0] m_preset = '0;
    logic [31:0] m_count  = '0;
    int          m_phase  = PH_IDLE;
    logic        m_if     = 1'b0;
    logic        m_irq    = 1'b0;

    logic [3:0]  old_ctrl;
    logic [31:0] old_preset;
    int          old_phase;
    bit          hit_ctrl, hit_preset, en_byte_written;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ctrl = '0; m_preset = '0; m_count = '0;
            m_phase = PH_IDLE; m_if = 1'b0; m_irq = 1'b0;
        end else begin
            old_ctrl        = m_ctrl;
            old_preset      = m_preset;
            old_phase       = m_phase;
            hit_ctrl        = we && addr == 2'd0;
            hit_preset      = we && addr == 2'd1;
            en_byte_written = hit_ctrl && be[0];

            m_irq = m_if && old_ctrl[3];
            if (en_byte_written) m_ctrl = wdata[3:0];
            for (int b = 0; b < 4; b++)
                if (hit_preset && be[b]) m_preset[8*b +: 8] = wdata[8*b +: 8];

            if (old_phase == PH_IDLE) begin
                if (old_ctrl[0]) m_phase = PH_LOAD;
            end else if (old_phase == PH_LOAD) begin
                m_count = old_preset;
                m_phase = PH_CNT;
            end else if (old_phase == PH_CNT) begin
                if (!old_ctrl[0]) m_phase = PH_IDLE;
                else begin
                    m_count = (m_count > 1) ? m_count - 1 : 32'd0;
                    if (m_count == 0) m_phase = PH_INT;
                end
            end else begin
                if (old_ctrl[2:1] == 2'b01) m_phase = PH_LOAD;
                else begin
                    m_phase = PH_IDLE;
                    if (!en_byte_written) m_ctrl[0] = 1'b0;
                end
            end

            if (hit_ctrl || hit_preset) m_if = 1'b0;
            if (m_phase == PH_INT && old_phase != PH_INT) m_if = 1'b1;
        end
    end

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        check("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
        check("rdata_vs_model", rdata, model_read(addr));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; we = 1'b1;
        tick();
        we = 1'b0; be = 4'h0;
    endtask

    int auto_exp [10] = '{3, 2, 1, 0, 0, 3, 2, 1, 0, 0};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        addr = 2'd0; we = 1'b0; be = 4'h0; wdata = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1 check("reset_rdata", rdata, 32'd0);
        end
        check("reset_irq", {31'd0, irq}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Byte enables, COUNT and reserved writes ignored
        wr(2'd1, 32'hAABBCCDD, 4'b1111);
        wr(2'd1, 32'h11223344, 4'b0101);
        addr = 2'd1; #1 check("preset_byte_en", rdata, 32'hAA22CC44);
        wr(2'd2, 32'h12345678, 4'b1111);
        addr = 2'd2; #1 check("count_write_ignored", rdata, 32'd0);
        wr(2'd3, 32'hFFFFFFFF, 4'b1111);
        addr = 2'd3; #1 check("addr3_reads_zero", rdata, 32'd0);

        // One-shot expiry, PRESET=5, CTRL=0x9 at E0
        wr(2'd1, 32'd5, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        addr = 2'd2;
        tick();
        for (int k = 2; k <= 6; k++) begin
            tick();
            check("oneshot_count", rdata, 32'(7 - k));
        end
        tick(); check("oneshot_count_E7", rdata, 32'd0);
        check("oneshot_irq_E7", {31'd0, irq}, 32'd0);
        tick(); check("oneshot_irq_E8", {31'd0, irq}, 32'd1);
        addr = 2'd0; #1 check("oneshot_ctrl_en_cleared", rdata, 32'h8);
        tick(); tick(); check("oneshot_irq_held", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h8, 4'hF);
        check("irq_on_clear_edge", {31'd0, irq}, 32'd1);
        tick(); check("irq_after_clear", {31'd0, irq}, 32'd0);

        // Mask: expiry with IM=0, then a CTRL write of IM=1 clears IF
        wr(2'd1, 32'd2, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        for (int k = 0; k < 6; k++) tick();
        check("masked_irq", {31'd0, irq}, 32'd0);
        addr = 2'd0; #1 check("masked_ctrl", rdata, 32'd0);
        wr(2'd0, 32'h8, 4'hF);
        tick(); tick();
        check("unmask_after_clear", {31'd0, irq}, 32'd0);

        // Auto-reload, PRESET=3, CTRL=0xB: INT at E5 and E10
        wr(2'd1, 32'd3, 4'hF);
        wr(2'd0, 32'hB, 4'hF);
        addr = 2'd2;
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("auto_count", rdata, 32'(auto_exp[k]));
            if (k >= 4) check("auto_irq", {31'd0, irq}, 32'd1);
        end
        wr(2'd0, 32'h0, 4'hF);
        tick(); tick();

        // CTRL write on the INT edge in one-shot: EN kept, restart via IDLE->LOAD
        wr(2'd1, 32'd2, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        addr = 2'd2;
        for (int k = 0; k < 4; k++) tick();
        check("coll_int_count", rdata, 32'd0);
        wr(2'd0, 32'h9, 4'hF);
        addr = 2'd0; #1 check("coll_ctrl_kept", rdata, 32'h9);
        addr = 2'd2;
        tick(); check("coll_idle_count", rdata, 32'd0);
        tick(); check("coll_reload_count", rdata, 32'd2);
        wr(2'd0, 32'h0, 4'hF);
        tick();

        // PRESET write on the INT-entry edge: set wins
        wr(2'd0, 32'h9, 4'hF);
        for (int k = 0; k < 3; k++) tick();
        wr(2'd1, 32'd7, 4'hF);
        tick(); check("preset_coll_irq", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h0, 4'hF);
        tick(); tick();

        // Reset mid-count in auto-reload after a first expiry
        wr(2'd1, 32'd5, 4'hF);
        wr(2'd0, 32'hB, 4'hF);
        addr = 2'd2;
        for (int k = 0; k < 10; k++) tick();
        check("pre_reset_count", rdata, 32'd4);
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        #1 reset = 1'b0;
        #1 check("reset_count_async", rdata, 32'd0);
        check("reset_irq_async", {31'd0, irq}, 32'd0);
        addr = 2'd1; #1 check("reset_preset_async", rdata, 32'd0);
        tick();
        reset = 1'b1;
        addr = 2'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_reset_idle", rdata, 32'd0);
        end
        addr = 2'd0; #1 check("post_reset_ctrl", rdata, 32'd0);
        wr(2'd1, 32'd5, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        addr = 2'd2;
        tick(); tick();
        check("restart_count", rdata, 32'd5);
        for (int k = 0; k < 8; k++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
